// File: rtl/gate_clock_ctrl_pkg.sv
// ============================================================================
// gate_clock_ctrl_pkg : state encoding, defaults and voting helpers shared by
//                       the readout gate clock controller files.
// Rev 1.0
// ============================================================================
`default_nettype none

package gate_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } gate_state_e;

   localparam int unsigned C_WAKE_CYCLES_DEF = 2;
   localparam int unsigned C_HOLD_W_DEF      = 4;
   localparam int unsigned C_CNT_W_DEF       = 16;

   function automatic int unsigned wake_cnt_width(input int unsigned wake_cycles);
      int unsigned w;
      w = $clog2(wake_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gate_idle_counter.sv
// ============================================================================
// gate_idle_counter : saturating up-counter with synchronous clear (priority)
//                     and increment enable.
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_idle_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/gate_clock_ctrl.sv
// ============================================================================
// gate_clock_ctrl : activity-driven gate enable for a readout gated-clock cell,
//                   with wake-up settling, idle hold-off and gated-cycle monitor.
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_clock_ctrl
   import gate_clock_ctrl_pkg::*;
#(
   parameter int unsigned WAKE_CYCLES = C_WAKE_CYCLES_DEF,
   parameter int unsigned HOLD_W      = C_HOLD_W_DEF,
   parameter int unsigned CNT_W       = C_CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable_gate,
   input  logic              i_act_req,
   input  logic              i_busy,
   input  logic [HOLD_W-1:0] i_hold_cycles,
   input  logic              i_cnt_clear,
   output logic              o_gate,
   output logic              o_gate_ready,
   output logic [CNT_W-1:0]  o_gated_cnt
);

   localparam int unsigned       WAKE_W      = wake_cnt_width(WAKE_CYCLES);
   localparam logic [WAKE_W-1:0] C_WAKE_LOAD = (WAKE_CYCLES == 0) ? '0 : WAKE_W'(WAKE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] C_HOLD_RST  = {HOLD_W{1'b1}};

   gate_state_e       w_state_v;
   logic [HOLD_W-1:0] w_hold_v;
   logic [WAKE_W-1:0] w_wake_v;
   gate_state_e       w_state_nxt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [WAKE_W-1:0] w_wake_nxt;
   logic              w_gate_nxt;
   logic              w_rdy_nxt;
   logic              w_activity;

   // Three identical copies of every state-holding register; all load the
   // same next value computed from the voted current value.
   for (genvar g = 0; g < 3; g++) begin : g_tmr
      gate_state_e       r_state;
      logic [HOLD_W-1:0] r_hold_cnt;
      logic [WAKE_W-1:0] r_wake_cnt;
      logic              r_gate;
      logic              r_rdy;
      logic [CNT_W-1:0]  w_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= C_HOLD_RST;
            r_wake_cnt <= '0;
            r_gate     <= 1'b1;
            r_rdy      <= 1'b1;
         end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_wake_cnt <= w_wake_nxt;
            r_gate     <= w_gate_nxt;
            r_rdy      <= w_rdy_nxt;
         end
      end

      gate_idle_counter #(
         .CNT_W (CNT_W)
      ) u_idle_cnt (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_clear (i_cnt_clear),
         .i_inc   (~o_gate),
         .o_count (w_cnt)
      );
   end

   assign w_state_v = gate_state_e'((g_tmr[0].r_state & g_tmr[1].r_state) |
                                    (g_tmr[0].r_state & g_tmr[2].r_state) |
                                    (g_tmr[1].r_state & g_tmr[2].r_state));
   assign w_hold_v  = (g_tmr[0].r_hold_cnt & g_tmr[1].r_hold_cnt) |
                      (g_tmr[0].r_hold_cnt & g_tmr[2].r_hold_cnt) |
                      (g_tmr[1].r_hold_cnt & g_tmr[2].r_hold_cnt);
   assign w_wake_v  = (g_tmr[0].r_wake_cnt & g_tmr[1].r_wake_cnt) |
                      (g_tmr[0].r_wake_cnt & g_tmr[2].r_wake_cnt) |
                      (g_tmr[1].r_wake_cnt & g_tmr[2].r_wake_cnt);

   assign w_activity = i_act_req | i_busy;

   always_comb begin
      w_state_nxt = w_state_v;
      w_hold_nxt  = w_hold_v;
      w_wake_nxt  = w_wake_v;

      if (!i_enable_gate) begin
         // Cell already forces the clock on, so no settling is needed.
         w_state_nxt = ST_ON;
      end else begin
         case (w_state_v)
            ST_OFF: begin
               if (w_activity) begin
                  if (WAKE_CYCLES == 0) begin
                     w_state_nxt = ST_ON;
                  end else begin
                     w_state_nxt = ST_WAKE;
                     w_wake_nxt  = C_WAKE_LOAD;
                  end
               end
            end
            ST_WAKE: begin
               if (w_wake_v == '0) begin
                  w_state_nxt = ST_ON;
               end else begin
                  w_wake_nxt = w_wake_v - WAKE_W'(1);
               end
            end
            ST_ON: begin
               if (!w_activity) begin
                  if (i_hold_cycles == '0) begin
                     w_state_nxt = ST_OFF;
                  end else begin
                     w_state_nxt = ST_HOLD;
                     w_hold_nxt  = i_hold_cycles;
                  end
               end
            end
            ST_HOLD: begin
               // Activity takes precedence over an expiring hold count.
               if (w_activity) begin
                  w_state_nxt = ST_ON;
               end else if (w_hold_v == '0) begin
                  w_state_nxt = ST_OFF;
               end else begin
                  w_hold_nxt = w_hold_v - HOLD_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_HOLD;
               w_hold_nxt  = C_HOLD_RST;
            end
         endcase
      end
   end

   // Outputs are registered decodes of the current state.
   assign w_gate_nxt = (w_state_v != ST_OFF);
   assign w_rdy_nxt  = (w_state_v == ST_ON) || (w_state_v == ST_HOLD);

   assign o_gate       = maj3(g_tmr[0].r_gate, g_tmr[1].r_gate, g_tmr[2].r_gate);
   assign o_gate_ready = maj3(g_tmr[0].r_rdy,  g_tmr[1].r_rdy,  g_tmr[2].r_rdy);
   assign o_gated_cnt  = (g_tmr[0].w_cnt & g_tmr[1].w_cnt) |
                         (g_tmr[0].w_cnt & g_tmr[2].w_cnt) |
                         (g_tmr[1].w_cnt & g_tmr[2].w_cnt);

endmodule

`default_nettype wire

// File: tb/tb_gate_clock_ctrl.sv
// ============================================================================
// tb_gate_clock_ctrl : directed + random stimulus against a timestamp-based
//                      reference model, with a behavioural gated-clock cell.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gate_clock_ctrl;

   localparam int WAKE = 2;
   localparam int HW   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int M_OFF = 0, M_WAKE = 1, M_ON = 2, M_HOLD = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b1;
   logic          act = 1'b0;
   logic          busy = 1'b0;
   logic [HW-1:0] hold = 4'd3;
   logic          clr = 1'b0;
   logic          o_gate;
   logic          o_gate_ready;
   logic [CW-1:0] o_gated_cnt;

   int total = 0;
   int bad   = 0;

   // reference model: mode plus absolute cycle deadlines
   int   m_mode;
   int   cyc;
   int   ready_at;
   int   off_at;
   logic m_gate;
   logic m_rdy;
   int   m_cnt;

   always #5 clk = ~clk;

   gate_clock_ctrl #(
      .WAKE_CYCLES (WAKE),
      .HOLD_W      (HW),
      .CNT_W       (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_enable_gate (en),
      .i_act_req     (act),
      .i_busy        (busy),
      .i_hold_cycles (hold),
      .i_cnt_clear   (clr),
      .o_gate        (o_gate),
      .o_gate_ready  (o_gate_ready),
      .o_gated_cnt   (o_gated_cnt)
   );

   // gated clock cell: enable latched while clk is low
   logic r_lat = 1'b1;
   logic w_gclk;
   always @(clk or o_gate or en) if (!clk) r_lat = o_gate | ~en;
   assign w_gclk = clk & r_lat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge w_gclk) check("gclk_rise_with_clk", {31'd0, clk}, 32'd1);
   always @(negedge w_gclk) check("gclk_fall_with_clk", {31'd0, clk}, 32'd0);

   task automatic model_reset();
      m_mode = M_HOLD;
      cyc    = 0;
      off_at = (1 << HW);      // all-ones hold count expires at this edge
      m_gate = 1'b1;
      m_rdy  = 1'b1;
      m_cnt  = 0;
   endtask

   task automatic model_step();
      logic ng, nr, a;
      cyc++;
      ng = (m_mode != M_OFF);
      nr = (m_mode == M_ON) || (m_mode == M_HOLD);
      if (clr)                          m_cnt = 0;
      else if (!m_gate && m_cnt < CMAX) m_cnt = m_cnt + 1;
      a = act | busy;
      if (!en) m_mode = M_ON;
      else case (m_mode)
         M_OFF:  if (a) begin
                    if (WAKE == 0) m_mode = M_ON;
                    else begin m_mode = M_WAKE; ready_at = cyc + WAKE; end
                 end
         M_WAKE: if (cyc == ready_at) m_mode = M_ON;
         M_ON:   if (!a) begin
                    if (hold == 0) m_mode = M_OFF;
                    else begin m_mode = M_HOLD; off_at = cyc + int'(hold) + 1; end
                 end
         default: if (a) m_mode = M_ON;
                  else if (cyc == off_at) m_mode = M_OFF;
      endcase
      m_gate = ng;
      m_rdy  = nr;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("gate",  {31'd0, o_gate},       {31'd0, m_gate});
      check("ready", {31'd0, o_gate_ready}, {31'd0, m_rdy});
      check("cnt",   {28'd0, o_gated_cnt},  m_cnt);
   endtask

   task automatic timeout(input string tag);
      total++;
      bad++;
      $error("FAIL timeout %s observed=expired expected=reached", tag);
   endtask

   task automatic run_until_mode(input int mode, input string tag);
      int n;
      n = 0;
      while (m_mode != mode && n < 100) begin cycle(); n++; end
      if (m_mode != mode) timeout(tag);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_gate",  {31'd0, o_gate},       32'd1);
      check("rst_ready", {31'd0, o_gate_ready}, 32'd1);
      check("rst_cnt",   {28'd0, o_gated_cnt},  32'd0);
      model_reset();
      rst_n = 1'b1;

      // idle after reset: hold all-ones expires, then gated off
      repeat (22) cycle();
      check("idle_gate_off", {31'd0, o_gate}, 32'd0);

      // single-cycle activity pulse from OFF, then hold-off
      act = 1'b1; cycle(); act = 1'b0;
      repeat (14) cycle();

      // busy in the very cycle the hold counter reaches zero
      act = 1'b1; cycle(); act = 1'b0; hold = 4'd3;
      begin
         int n;
         n = 0;
         while (!(m_mode == M_HOLD && cyc + 1 == off_at) && n < 100) begin cycle(); n++; end
         if (n >= 100) timeout("hold_zero");
      end
      busy = 1'b1; cycle(); busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("no_gate_off_pulse", {31'd0, o_gate}, 32'd1);
      end

      // enable forced low while OFF
      run_until_mode(M_OFF, "off_before_en");
      repeat (2) cycle();
      en = 1'b0; cycle(); cycle();
      check("en_forces_gate",  {31'd0, o_gate},       32'd1);
      check("en_forces_ready", {31'd0, o_gate_ready}, 32'd1);
      repeat (2) cycle();
      en = 1'b1; hold = 4'd0;

      // saturation and clear while gated off
      repeat (20) cycle();
      check("cnt_saturated", {28'd0, o_gated_cnt}, CMAX);
      clr = 1'b1; cycle(); clr = 1'b0;
      check("cnt_cleared", {28'd0, o_gated_cnt}, 32'd0);
      cycle();
      check("cnt_after_clear", {28'd0, o_gated_cnt}, 32'd1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         act  = ($urandom_range(0, 99) < 20);
         busy = ($urandom_range(0, 99) < 10);
         en   = ($urandom_range(0, 99) >= 4);
         clr  = ($urandom_range(0, 99) < 3);
         hold = HW'($urandom_range(0, 5));
         cycle();
      end
      act = 1'b0; busy = 1'b0; en = 1'b1; clr = 1'b0; hold = 4'd2;

      // asynchronous reset while waking up
      run_until_mode(M_OFF, "off_before_wake");
      repeat (3) cycle();
      act = 1'b1; cycle(); act = 1'b0;
      check("in_wake_not_ready", {31'd0, o_gate_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_gate",  {31'd0, o_gate},       32'd1);
      check("async_rst_ready", {31'd0, o_gate_ready}, 32'd1);
      check("async_rst_cnt",   {28'd0, o_gated_cnt},  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat (25) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
